// File: rtl/posit_decode_stage_if.sv
// Shared posit decode types and the handshake bundle of posit_decode_stage.
// posit_pkg : field widths, NaR pattern, classification and decoded-payload structs.
// posit_decode_stage_if : operand/tag/valid/ready/flush in, decoded fields/valid/busy out.
//   slave modport  = decoder view, master modport = producer/consumer view.

package posit_pkg;
  localparam int unsigned PositWidth = 32;
  localparam int unsigned ScaleWidth = 8;
  localparam int unsigned MantWidth  = 28;
  localparam logic [PositWidth-1:0] POSIT_NAR = 32'h8000_0000;

  // Exactly one bit set per decoded operand.
  typedef struct packed {
    logic is_zero;
    logic is_NaR;
    logic is_pos;
    logic is_neg;
  } posit_info_t;

  typedef struct packed {
    logic                  sign;
    logic [ScaleWidth-1:0] scale;
    logic [MantWidth-1:0]  mant;
    posit_info_t           info;
  } posit_dec_t;
endpackage

interface posit_decode_stage_if #(
  parameter int unsigned TagWidth = 1
);
  logic [posit_pkg::PositWidth-1:0] operand_i;
  logic [TagWidth-1:0]              tag_i;
  logic                             in_valid_i;
  logic                             in_ready_o;
  logic                             flush_i;
  logic                             sign_o;
  logic [posit_pkg::ScaleWidth-1:0] scale_o;
  logic [posit_pkg::MantWidth-1:0]  mant_o;
  posit_pkg::posit_info_t           info_o;
  logic [TagWidth-1:0]              tag_o;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic                             busy_o;

  modport slave (
    input  operand_i, tag_i, in_valid_i, flush_i, out_ready_i,
    output in_ready_o, sign_o, scale_o, mant_o, info_o, tag_o, out_valid_o, busy_o
  );

  modport master (
    output operand_i, tag_i, in_valid_i, flush_i, out_ready_i,
    input  in_ready_o, sign_o, scale_o, mant_o, info_o, tag_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/posit_decode_stage.sv
// Pipelined posit32 (es=2) operand decoder.
// Ports: clk_i, rst_ni (async, active low), bus (posit_decode_stage_if.slave):
//   operand_i/tag_i/in_valid_i -> in_ready_o, flush_i kills in-flight entries,
//   sign_o/scale_o/mant_o/info_o/tag_o/out_valid_o <- out_ready_i, busy_o.
// NumPipeRegs = 0..4 register stages after decode (0 = combinational path).

module posit_decode_stage
  import posit_pkg::*;
#(
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  posit_decode_stage_if.slave   bus
);

  localparam int unsigned RunWidth = 5;
  localparam int unsigned ShWidth  = 6;

  logic                  w_sign;
  logic [30:0]           w_abs;
  logic [RunWidth-1:0]   w_run;
  logic                  w_done;
  logic [ShWidth-1:0]    w_shamt;
  logic [28:0]           w_rem;
  logic [1:0]            w_e;
  logic [ScaleWidth-1:0] w_k;
  posit_dec_t            w_dec;

  // Decode: regime run length, then exponent and fraction from what is left.
  always_comb begin : decode
    w_dec   = '0;
    w_done  = 1'b0;
    w_run   = '0;
    w_sign  = bus.operand_i[31];
    w_abs   = 31'(w_sign ? (32'd0 - bus.operand_i) : bus.operand_i);
    for (int i = 30; i >= 0; i--) begin
      if (!w_done && (w_abs[i] == w_abs[30])) w_run = w_run + RunWidth'(1);
      else                                    w_done = 1'b1;
    end
    // Drop regime plus terminator; bits shifted in from below read as 0.
    w_shamt = ShWidth'(w_run) + ShWidth'(1);
    w_rem   = 29'((w_abs << w_shamt) >> 2);
    w_e     = w_rem[28:27];
    w_k     = w_abs[30] ? (ScaleWidth'(w_run) - ScaleWidth'(1))
                        : (ScaleWidth'(0) - ScaleWidth'(w_run));
    if (bus.operand_i == '0) begin
      w_dec.info.is_zero = 1'b1;
    end else if (bus.operand_i == POSIT_NAR) begin
      w_dec.info.is_NaR = 1'b1;
    end else begin
      w_dec.sign        = w_sign;
      w_dec.scale       = (w_k << 2) + {6'd0, w_e};
      w_dec.mant        = {1'b1, w_rem[26:0]};
      w_dec.info.is_pos = ~w_sign;
      w_dec.info.is_neg = w_sign;
    end
  end

  if (NumPipeRegs > 4) begin : g_bad_depth
    $fatal(1, "posit_decode_stage: NumPipeRegs must be 0..4");
  end

  if (NumPipeRegs == 0) begin : g_comb
    // Pure combinational path; flush and clock have no state to act on.
    logic w_unused;
    assign w_unused        = ^{bus.flush_i, clk_i, rst_ni};
    assign bus.in_ready_o  = bus.out_ready_i;
    assign bus.out_valid_o = bus.in_valid_i;
    assign bus.sign_o      = w_dec.sign;
    assign bus.scale_o     = w_dec.scale;
    assign bus.mant_o      = w_dec.mant;
    assign bus.info_o      = w_dec.info;
    assign bus.tag_o       = bus.tag_i;
    assign bus.busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0]        r_valid;
    posit_dec_t          r_pl      [N];
    logic [TagWidth-1:0] r_tag     [N];
    logic [N:0]          w_ready;
    logic [N-1:0]        w_src_valid;
    posit_dec_t          w_src_pl  [N];
    logic [TagWidth-1:0] w_src_tag [N];

    assign w_ready[N] = bus.out_ready_i;

    // Stage i is ready when empty or when its content moves on this cycle.
    for (genvar i = 0; i < N; i++) begin : g_link
      assign w_ready[i] = ~r_valid[i] | w_ready[i+1];
      if (i == 0) begin : g_head
        assign w_src_valid[i] = bus.in_valid_i & ~bus.flush_i;
        assign w_src_pl[i]    = w_dec;
        assign w_src_tag[i]   = bus.tag_i;
      end else begin : g_body
        assign w_src_valid[i] = r_valid[i-1];
        assign w_src_pl[i]    = r_pl[i-1];
        assign w_src_tag[i]   = r_tag[i-1];
      end
    end

    // Valid bits follow ready; payload loads only on an actual transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin : pipe_regs
      if (!rst_ni) begin
        r_valid <= '0;
        for (int i = 0; i < N; i++) begin
          r_pl[i]  <= '0;
          r_tag[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (bus.flush_i)     r_valid[i] <= 1'b0;
          else if (w_ready[i]) r_valid[i] <= w_src_valid[i];
          if (w_ready[i] && w_src_valid[i] && !bus.flush_i) begin
            r_pl[i]  <= w_src_pl[i];
            r_tag[i] <= w_src_tag[i];
          end
        end
      end
    end

    assign bus.in_ready_o  = w_ready[0];
    assign bus.out_valid_o = r_valid[N-1];
    assign bus.sign_o      = r_pl[N-1].sign;
    assign bus.scale_o     = r_pl[N-1].scale;
    assign bus.mant_o      = r_pl[N-1].mant;
    assign bus.info_o      = r_pl[N-1].info;
    assign bus.tag_o       = r_tag[N-1];
    assign bus.busy_o      = |r_valid;
  end

endmodule

// File: tb/tb_posit_decode_stage.sv
// Self-checking bench for posit_decode_stage at depths 0..3 with a cursor-based
// reference decoder and a tag scoreboard for the randomized stream.

module tb_posit_decode_stage;
  import posit_pkg::*;

  localparam int unsigned TW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  posit_decode_stage_if #(.TagWidth(TW)) if0 ();
  posit_decode_stage_if #(.TagWidth(TW)) if1 ();
  posit_decode_stage_if #(.TagWidth(TW)) if2 ();
  posit_decode_stage_if #(.TagWidth(TW)) if3 ();

  posit_decode_stage #(.NumPipeRegs(0), .TagWidth(TW)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0.slave));
  posit_decode_stage #(.NumPipeRegs(1), .TagWidth(TW)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1.slave));
  posit_decode_stage #(.NumPipeRegs(2), .TagWidth(TW)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2.slave));
  posit_decode_stage #(.NumPipeRegs(3), .TagWidth(TW)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(if3.slave));

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [40:0]   dec;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t sb[$];

  logic [31:0] dir_ops [9] = '{32'h4000_0000, 32'hC000_0000, 32'h4400_0000, 32'h5000_0000,
                               32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000,
                               32'h4800_0000};
  // {sign, scale, mant, info(zero,NaR,pos,neg)}
  logic [40:0] dir_exp [9] = '{{1'b0, 8'h00, 28'h800_0000, 4'b0010},
                               {1'b1, 8'h00, 28'h800_0000, 4'b0001},
                               {1'b0, 8'h00, 28'hC00_0000, 4'b0010},
                               {1'b0, 8'h02, 28'h800_0000, 4'b0010},
                               {1'b0, 8'h78, 28'h800_0000, 4'b0010},
                               {1'b0, 8'h88, 28'h800_0000, 4'b0010},
                               {1'b0, 8'h00, 28'h000_0000, 4'b0100},
                               {1'b0, 8'h00, 28'h000_0000, 4'b1000},
                               {1'b0, 8'h01, 28'h800_0000, 4'b0010}};

  // Walks the bit string with a read cursor: regime, terminator, 2 exponent bits, fraction.
  function automatic logic [40:0] ref_decode(input logic [31:0] op);
    logic [31:0] a;
    logic        s, b;
    int pos, m, e, k, scale, frac;
    if (op == 32'd0)         return {1'b0, 8'd0, 28'd0, 4'b1000};
    if (op == 32'h8000_0000) return {1'b0, 8'd0, 28'd0, 4'b0100};
    s = op[31];
    a = s ? (32'd0 - op) : op;
    pos = 30; b = a[30]; m = 0;
    while (pos >= 0 && a[pos] == b) begin m++; pos--; end
    if (pos >= 0) pos--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    frac = 0;
    for (int j = 0; j < 27; j++) begin
      frac = frac * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    k = b ? (m - 1) : -m;
    scale = 4 * k + e;
    return {s, 8'(scale), 28'((1 << 27) + frac), s ? 4'b0001 : 4'b0010};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2, 3: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Watchdog: every loop below is bounded; this only catches a stuck simulator.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  int acc, got, cyc;
  logic [31:0] t4_ops [4];
  exp_t e_item;

  initial begin
    if0.operand_i = '0; if0.tag_i = '0; if0.in_valid_i = 1'b0; if0.flush_i = 1'b0; if0.out_ready_i = 1'b1;
    if1.operand_i = '0; if1.tag_i = '0; if1.in_valid_i = 1'b0; if1.flush_i = 1'b0; if1.out_ready_i = 1'b1;
    if2.operand_i = '0; if2.tag_i = '0; if2.in_valid_i = 1'b0; if2.flush_i = 1'b0; if2.out_ready_i = 1'b1;
    if3.operand_i = '0; if3.tag_i = '0; if3.in_valid_i = 1'b0; if3.flush_i = 1'b0; if3.out_ready_i = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid1", 64'(if1.out_valid_o), 64'd0);
    chk("rst_busy3", 64'(if3.busy_o), 64'd0);
    chk("rst_data2", 64'({if2.sign_o, if2.scale_o, if2.mant_o, if2.info_o, if2.tag_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready1", 64'(if1.in_ready_o), 64'd1);
    chk("rel_ready3", 64'(if3.in_ready_o), 64'd1);
    @(posedge clk); #1;

    // Directed operands through depth 1, one-cycle latency
    for (int i = 0; i < 9; i++) begin
      if1.operand_i = dir_ops[i]; if1.tag_i = TW'(i); if1.in_valid_i = 1'b1;
      @(posedge clk); #1;
      if1.in_valid_i = 1'b0;
      @(negedge clk);
      chk($sformatf("dir_valid_%0d", i), 64'(if1.out_valid_o), 64'd1);
      chk($sformatf("dir_dec_%08h", dir_ops[i]),
          64'({if1.sign_o, if1.scale_o, if1.mant_o, if1.info_o}), 64'(dir_exp[i]));
      chk($sformatf("dir_tag_%0d", i), 64'(if1.tag_o), 64'(i));
      @(posedge clk); #1;
    end

    // Random operands through depth 1 against the reference model
    for (int i = 0; i < 100; i++) begin
      if1.operand_i = rand_op(); if1.tag_i = TW'($urandom); if1.in_valid_i = 1'b1;
      @(posedge clk); #1;
      if1.in_valid_i = 1'b0;
      @(negedge clk);
      chk($sformatf("rnd1_dec_%08h", if1.operand_i),
          64'({if1.sign_o, if1.scale_o, if1.mant_o, if1.info_o}), 64'(ref_decode(if1.operand_i)));
      chk("rnd1_tag", 64'(if1.tag_o), 64'(if1.tag_i));
      @(posedge clk); #1;
    end

    // Depth 0: combinational pass-through, flush ignored
    for (int i = 0; i < 20; i++) begin
      if0.operand_i   = rand_op();
      if0.tag_i       = TW'($urandom);
      if0.in_valid_i  = 1'($urandom_range(0, 1));
      if0.out_ready_i = 1'($urandom_range(0, 1));
      if0.flush_i     = 1'($urandom_range(0, 1));
      #1;
      chk("n0_dec", 64'({if0.sign_o, if0.scale_o, if0.mant_o, if0.info_o}), 64'(ref_decode(if0.operand_i)));
      chk("n0_valid", 64'(if0.out_valid_o), 64'(if0.in_valid_i));
      chk("n0_ready", 64'(if0.in_ready_o), 64'(if0.out_ready_i));
      chk("n0_tag", 64'(if0.tag_o), 64'(if0.tag_i));
    end
    @(posedge clk); #1;

    // Depth 2 backpressure: only two captured, output held stable
    for (int i = 0; i < 4; i++) t4_ops[i] = rand_op();
    if2.out_ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      if2.in_valid_i = 1'b1; if2.operand_i = t4_ops[acc]; if2.tag_i = TW'(acc);
      @(negedge clk);
      if (if2.in_ready_o) acc++;
      @(posedge clk); #1;
    end
    chk("bp_captured", 64'(acc), 64'd2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(if2.in_ready_o), 64'd0);
      chk("bp_out_valid", 64'(if2.out_valid_o), 64'd1);
      chk("bp_hold_dec", 64'({if2.sign_o, if2.scale_o, if2.mant_o, if2.info_o}), 64'(ref_decode(t4_ops[0])));
      chk("bp_hold_tag", 64'(if2.tag_o), 64'd0);
      @(posedge clk); #1;
    end
    if2.out_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if2.in_valid_i = (acc < 4);
      if (acc < 4) begin if2.operand_i = t4_ops[acc]; if2.tag_i = TW'(acc); end
      @(negedge clk);
      if (if2.in_valid_i && if2.in_ready_o) acc++;
      if (if2.out_valid_o) begin
        chk("bp_drain_dec", 64'({if2.sign_o, if2.scale_o, if2.mant_o, if2.info_o}), 64'(ref_decode(t4_ops[got])));
        chk("bp_drain_tag", 64'(if2.tag_o), 64'(got));
        got++;
      end
      @(posedge clk); #1;
    end
    chk("bp_drain_count", 64'(got), 64'd4);
    if2.in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_no_dup", 64'(if2.out_valid_o), 64'd0);
    @(posedge clk); #1;

    // Depth 2 random stream with random backpressure, scoreboarded by tag
    for (int c = 0; c < 400; c++) begin
      if2.in_valid_i  = ($urandom_range(0, 3) != 0);
      if2.operand_i   = rand_op();
      if2.tag_i       = TW'($urandom);
      if2.out_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (if2.out_valid_o && if2.out_ready_i) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e_item = sb.pop_front();
          chk("sb_dec", 64'({if2.sign_o, if2.scale_o, if2.mant_o, if2.info_o}), 64'(e_item.dec));
          chk("sb_tag", 64'(if2.tag_o), 64'(e_item.tag));
        end
      end
      if (if2.in_valid_i && if2.in_ready_o) begin
        e_item.dec = ref_decode(if2.operand_i);
        e_item.tag = if2.tag_i;
        sb.push_back(e_item);
      end
      @(posedge clk); #1;
    end
    if2.in_valid_i = 1'b0; if2.out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if2.out_valid_o && sb.size() != 0) begin
        e_item = sb.pop_front();
        chk("sb_drain_dec", 64'({if2.sign_o, if2.scale_o, if2.mant_o, if2.info_o}), 64'(e_item.dec));
        chk("sb_drain_tag", 64'(if2.tag_o), 64'(e_item.tag));
      end
      @(posedge clk); #1;
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Depth 3 flush with three in flight and a simultaneous valid input
    if3.out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if3.in_valid_i = 1'b1; if3.operand_i = rand_op(); if3.tag_i = TW'(c);
      @(posedge clk); #1;
    end
    if3.in_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_pre_busy", 64'(if3.busy_o), 64'd1);
    chk("fl_pre_ready", 64'(if3.in_ready_o), 64'd0);
    @(posedge clk); #1;
    if3.flush_i = 1'b1; if3.in_valid_i = 1'b1; if3.out_ready_i = 1'b1;
    @(posedge clk); #1;
    if3.flush_i = 1'b0; if3.in_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_busy", 64'(if3.busy_o), 64'd0);
    chk("fl_valid", 64'(if3.out_valid_o), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fl_not_captured", 64'(if3.out_valid_o), 64'd0);
    end
    @(posedge clk); #1;

    // Reset mid-stream, then fresh operand latency on depth 3
    if1.in_valid_i = 1'b1; if3.in_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if1.operand_i = rand_op(); if3.operand_i = rand_op();
      @(posedge clk); #1;
    end
    chk("mr_pre_valid1", 64'(if1.out_valid_o), 64'd1);
    chk("mr_pre_valid3", 64'(if3.out_valid_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid1", 64'(if1.out_valid_o), 64'd0);
    chk("mr_valid3", 64'(if3.out_valid_o), 64'd0);
    chk("mr_busy3", 64'(if3.busy_o), 64'd0);
    if1.in_valid_i = 1'b0; if3.in_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_ready1", 64'(if1.in_ready_o), 64'd1);
    chk("mr_ready3", 64'(if3.in_ready_o), 64'd1);
    @(posedge clk); #1;
    if3.operand_i = 32'h4800_0000; if3.tag_i = TW'(8'hA5); if3.in_valid_i = 1'b1;
    @(posedge clk); #1;
    if3.in_valid_i = 1'b0;
    cyc = 1;
    while (!if3.out_valid_o && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mr_latency3", 64'(cyc), 64'd3);
    chk("mr_scale", 64'(if3.scale_o), 64'd1);
    chk("mr_dec", 64'({if3.sign_o, if3.scale_o, if3.mant_o, if3.info_o}), 64'(dir_exp[8]));
    chk("mr_tag", 64'(if3.tag_o), 64'h0A5);
    chk("mr_no_stale1", 64'(if1.out_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
